eightone_mux: RTL and testbench
===============================

Name: eightone_mux

Overview:
- 8-to-1 selector built structurally as a three-level tree of 2:1 muxes, with a combinational output and a registered copy.
- Data path width is parameterized; the default is a 1-bit lane per input.
- Sits in datapath glue logic wherever one of eight sources is steered onto a single line.
- The registered output with valid tracking is the pipelined variant used by clocked consumers.

Parameters:
- W, default 1: bit width of each of the 8 data lanes.
- NUM_IN, default 8: number of inputs. Fixed at 8; a different value is a configuration error flagged at elaboration.
- SEL_W, default 3: select width. Must equal clog2(NUM_IN).

Ports:
- clk, input, 1: single clock; all sequential state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- d, input, 8*W: packed data. Lane i occupies bits [i*W +: W]; with W=1, bit i is lane i.
- sel, input, 3: lane select, unsigned binary 0..7.
- en, input, 1: capture enable for the registered output.
- y, output, W: combinational selected lane.
- y_q, output, W: registered selected lane.
- y_valid, output, 1: high when y_q holds a captured value.

Behaviour:
- Combinational path:
  - y = lane[sel] at all times, with zero latency.
  - No dependence on clk, rst or en.
  - All 8 sel codes are legal; there is no out-of-range case.
- Tree structure:
  - Level 0: sel[0] picks between lanes (0,1), (2,3), (4,5), (6,7), giving four results.
  - Level 1: sel[1] picks between the pairs, giving two results.
  - Level 2: sel[2] picks the final value.
  - Each mux2 outputs a when s=0 and b when s=1.
- Registered path, on each rising clk edge:
  - If en=1: y_q <= lane[sel] and y_valid <= 1.
  - If en=0: y_q and y_valid hold their values.
- Latency: y_q reflects the d/sel sampled at the edge where en=1, so it appears 1 cycle after those inputs are presented.
- Reset:
  - rst=1 immediately forces y_q=0 and y_valid=0, regardless of clk.
  - Reset asserted mid-operation discards the held value.
  - While rst is high, edges with en=1 do not capture.
  - The first capture occurs on the first rising edge after rst deasserts with en=1.
  - y stays live during reset.
- Simultaneous events: d or sel changing exactly at the edge is a bench timing violation. Capture uses the values settled before the edge.
- Unknown sel (X/Z): y is don't-care. No recovery logic is required.

Decomposition:
- Shared package eightone_mux_pkg holds:
  - localparam NUM_IN=8 and SEL_W=3;
  - the lane-extraction helper function (index * W slicing);
  - the typedef sel_t = logic [2:0].
- One sub-module, mux2 (parameter W; ports a, b, s, y), instantiated 7 times in the tree.
- The register stage lives in the top level.

Test Plan:
- d=8'b10101010, sel stepped 000,001,010,011 at 10 ns intervals -> y = 0,1,0,1.
- Same d, sel 100..111 -> y = 0,1,0,1; then d=8'b01010101 swept over all 8 sel codes -> y is the inverse pattern. Covers every tree leg.
- rst=1 then released, en=1, d=8'hF0, sel=3'd5 -> y_q=0 and y_valid=0 during reset; 1 cycle after the release edge, y_q=1 and y_valid=1.
- en=0 while sel and d change -> y tracks immediately; y_q and y_valid unchanged.
- rst pulse asserted between clock edges while y_valid=1 -> y_q=0 and y_valid=0 immediately, with no clock edge needed.
- W=4, d=32'h76543210, sel=0..7 -> y = 0..7 in hex, and y_q follows one cycle later with en=1.

Source files
------------

// File: rtl/eightone_mux_pkg.sv
// eightone_mux shared definitions.
// Lane geometry, select type and slicing helper.
package eightone_mux_pkg;

    localparam int NUM_IN = 8;
    localparam int SEL_W  = 3;

    typedef logic [SEL_W-1:0] sel_t;

    // LSB position of lane idx inside the packed data bus
    function automatic int lane_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/eightone_mux_mux2.sv
// eightone_mux 2:1 leaf/node selector.
// Passes a when s=0, b when s=1.
module mux2 #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/eightone_mux.sv
// eightone_mux top: 3-level mux2 tree with a combinational output
// and an enable-gated registered copy tracked by a valid flag.
module eightone_mux
    import eightone_mux_pkg::*;
#(
    parameter int W      = 1,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IN*W-1:0] d,
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    output logic [W-1:0]        y,
    output logic [W-1:0]        y_q,
    output logic                y_valid
);

    // The tree below is hard-wired for eight lanes and a 3-bit select.
    if (NUM_IN != eightone_mux_pkg::NUM_IN) begin : g_bad_num_in
        $error("eightone_mux: NUM_IN must be 8");
    end
    if (SEL_W != $clog2(NUM_IN)) begin : g_bad_sel_w
        $error("eightone_mux: SEL_W must equal clog2(NUM_IN)");
    end

    sel_t         s;
    logic [W-1:0] lane [8];
    logic [W-1:0] l0   [4];
    logic [W-1:0] l1   [2];

    assign s = sel;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign lane[i] = d[lane_lsb(i, W) +: W];
    end

    for (genvar i = 0; i < 4; i++) begin : g_lvl0
        mux2 #(.W(W)) u_m (
            .a(lane[2*i]),
            .b(lane[2*i+1]),
            .s(s[0]),
            .y(l0[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_lvl1
        mux2 #(.W(W)) u_m (
            .a(l0[2*i]),
            .b(l0[2*i+1]),
            .s(s[1]),
            .y(l1[i])
        );
    end

    mux2 #(.W(W)) u_lvl2 (
        .a(l1[0]),
        .b(l1[1]),
        .s(s[2]),
        .y(y)
    );

    // Capture the selected lane when enabled; reset clears value and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            y_valid <= 1'b0;
        end else if (en) begin
            y_q     <= y;
            y_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_eightone_mux.sv
// eightone_mux testbench: vector table, scoreboard queue for the
// registered path, and hand-written reset/hold sequences.
module tb_eightone_mux;

    typedef struct {
        logic [7:0] d;
        logic [2:0] sel;
        logic       y;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  d;
    logic [2:0]  sel;
    logic        y;
    logic        y_q;
    logic        y_valid;
    logic [31:0] d4;
    logic [2:0]  sel4;
    logic [3:0]  y4;
    logic [3:0]  y_q4;
    logic        y_valid4;

    int checks = 0;
    int errors = 0;

    logic       q1 [$];
    logic [3:0] q4 [$];
    vec_t       vecs [16];

    eightone_mux #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .d(d), .sel(sel), .en(en),
        .y(y), .y_q(y_q), .y_valid(y_valid)
    );

    eightone_mux #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .d(d4), .sel(sel4), .en(en),
        .y(y4), .y_q(y_q4), .y_valid(y_valid4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i]   = '{8'b10101010, 3'(i), 1'(i % 2)};
            vecs[i+8] = '{8'b01010101, 3'(i), 1'((i + 1) % 2)};
        end

        rst = 1'b1; en = 1'b1; d = 8'hF0; sel = 3'd5;
        d4 = 32'h0; sel4 = 3'd0;
        #1;
        chk("rst_y_q", 32'(y_q), 32'h0);
        chk("rst_valid", 32'(y_valid), 32'h0);
        chk("rst_y_live", 32'(y), 32'h1);
        chk("rst_y_q4", 32'(y_q4), 32'h0);
        @(posedge clk); #1;
        chk("rst_edge_y_q", 32'(y_q), 32'h0);
        chk("rst_edge_valid", 32'(y_valid), 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("first_cap_y_q", 32'(y_q), 32'h1);
        chk("first_cap_valid", 32'(y_valid), 32'h1);

        foreach (vecs[i]) begin
            @(negedge clk);
            d = vecs[i].d; sel = vecs[i].sel; en = 1'b1;
            q1.push_back(vecs[i].y);
            #1 chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
            @(posedge clk); #1;
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL vec%0d_sb: actual=empty required=entry", i);
            end else begin
                chk($sformatf("vec%0d_y_q", i), 32'(y_q),
                    32'(q1.pop_front()));
            end
        end

        @(negedge clk);
        d = 8'hFF; sel = 3'd0; en = 1'b1;
        @(posedge clk); #1;
        chk("hold_load", 32'(y_q), 32'h1);
        @(negedge clk);
        en = 1'b0; d = 8'h00; sel = 3'd3;
        #1 chk("hold_y_track", 32'(y), 32'h0);
        @(posedge clk); #1;
        chk("hold_y_q", 32'(y_q), 32'h1);
        chk("hold_valid", 32'(y_valid), 32'h1);

        @(negedge clk);
        d = 8'h04; sel = 3'd2;
        #2 rst = 1'b1;
        #1;
        chk("async_y_q", 32'(y_q), 32'h0);
        chk("async_valid", 32'(y_valid), 32'h0);
        chk("async_y_live", 32'(y), 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_noen_valid", 32'(y_valid), 32'h0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d4 = 32'h76543210; sel4 = 3'(i); en = 1'b1;
            q4.push_back(4'(i));
            #1 chk($sformatf("w4_y_%0d", i), 32'(y4), 32'(i));
            @(posedge clk); #1;
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL w4_sb%0d: actual=empty required=entry", i);
            end else begin
                chk($sformatf("w4_y_q_%0d", i), 32'(y_q4),
                    32'(q4.pop_front()));
            end
            chk($sformatf("w4_valid_%0d", i), 32'(y_valid4), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
